// File: rtl/task_answer_arbiter.sv
// Round-robin packet arbiter merging N_TASKS answer streams into one.
// A granted requester owns the output until its last word is accepted or
// until it stalls for too long, in which case a marker word is emitted.
module task_answer_arbiter #(
   parameter int N_TASKS    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 1024
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [N_TASKS-1:0]              i_valid,
   output logic [N_TASKS-1:0]              o_ready,
   input  logic [N_TASKS*DATA_WIDTH-1:0]   i_data,
   input  logic [N_TASKS-1:0]              i_last,
   output logic                            o_valid,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic                            o_last,
   input  logic                            i_ready,
   output logic [2:0]                      o_id,
   output logic [N_TASKS-1:0]              o_err,
   output logic [15:0]                     o_pkt_cnt
);

   localparam int                  STALL_W     = $clog2(TIMEOUT) + 1;
   localparam logic [STALL_W-1:0]  STALL_LIMIT = STALL_W'(TIMEOUT - 2);
   localparam logic [N_TASKS-1:0]  ONE_HOT0    = {{(N_TASKS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      XFER  = 2'd2,
      ABORT = 2'd3
   } state_t;

   state_t                         state_r, state_n_s;
   logic [2:0]                     grant_r, grant_n_s;
   logic [2:0]                     last_grant_r, last_grant_n_s;
   logic [STALL_W-1:0]             stall_r, stall_n_s;
   logic [N_TASKS-1:0]             err_r, err_n_s;
   logic [15:0]                    pkt_cnt_r, pkt_cnt_n_s;

   logic [N_TASKS-1:0]             g_sel_s;
   logic                           g_valid_s;
   logic                           g_last_s;
   logic [N_TASKS*DATA_WIDTH-1:0]  data_shift_s;
   logic [DATA_WIDTH-1:0]          g_data_s;
   logic [31:0]                    abort_word_s;

   // Pick the first requesting index after 'last', wrapping around.
   function automatic logic [2:0] rr_pick(input logic [N_TASKS-1:0] req,
                                          input logic [2:0]         last);
      logic [2:0]         pick;
      logic               found;
      logic [N_TASKS-1:0] sh;
      int                 idx;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= N_TASKS; i++) begin
         idx = (int'(last) + i) % N_TASKS;
         sh  = req >> idx;
         if (!found && sh[0]) begin
            pick  = 3'(idx);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

   // Views of the currently granted requester.
   assign g_sel_s      = ONE_HOT0 << grant_r;
   assign g_valid_s    = |(i_valid & g_sel_s);
   assign g_last_s     = |(i_last & g_sel_s) & g_valid_s;
   assign data_shift_s = i_data >> (int'(grant_r) * DATA_WIDTH);
   assign g_data_s     = data_shift_s[DATA_WIDTH-1:0];
   assign abort_word_s = 32'hDEAD_0000 | {29'd0, grant_r};

   // Next-state and output decode; data path is a zero-latency pass-through.
   always_comb begin
      state_n_s      = state_r;
      grant_n_s      = grant_r;
      last_grant_n_s = last_grant_r;
      stall_n_s      = stall_r;
      err_n_s        = err_r;
      pkt_cnt_n_s    = pkt_cnt_r;
      o_valid        = 1'b0;
      o_data         = '0;
      o_last         = 1'b0;
      o_ready        = '0;
      case (state_r)
         IDLE: begin
            if (|i_valid) begin
               grant_n_s = rr_pick(i_valid, last_grant_r);
               state_n_s = GRANT;
            end else begin
               state_n_s = IDLE;
            end
         end
         GRANT: begin
            stall_n_s = '0;
            state_n_s = XFER;
         end
         XFER: begin
            o_valid = g_valid_s;
            o_data  = g_data_s;
            o_last  = g_last_s;
            o_ready = i_ready ? g_sel_s : '0;
            if (g_valid_s && i_ready && g_last_s) begin
               state_n_s      = IDLE;
               last_grant_n_s = grant_r;
               pkt_cnt_n_s    = pkt_cnt_r + 16'd1;
               stall_n_s      = '0;
            end else if (g_valid_s) begin
               // Backpressure with data present is not a stall.
               stall_n_s = '0;
            end else if (stall_r >= STALL_LIMIT) begin
               state_n_s = ABORT;
            end else begin
               stall_n_s = stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
            end
         end
         ABORT: begin
            o_valid = 1'b1;
            o_last  = 1'b1;
            o_data  = DATA_WIDTH'(abort_word_s);
            if (i_ready) begin
               err_n_s        = err_r | g_sel_s;
               last_grant_n_s = grant_r;
               pkt_cnt_n_s    = pkt_cnt_r + 16'd1;
               stall_n_s      = '0;
               state_n_s      = IDLE;
            end else begin
               state_n_s = ABORT;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
   end

   // State and bookkeeping registers; reset drops any packet in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= IDLE;
         grant_r      <= 3'd0;
         last_grant_r <= 3'(N_TASKS - 1);
         stall_r      <= '0;
         err_r        <= '0;
         pkt_cnt_r    <= 16'd0;
      end else begin
         state_r      <= state_n_s;
         grant_r      <= grant_n_s;
         last_grant_r <= last_grant_n_s;
         stall_r      <= stall_n_s;
         err_r        <= err_n_s;
         pkt_cnt_r    <= pkt_cnt_n_s;
      end
   end

   assign o_id      = grant_r;
   assign o_err     = err_r;
   assign o_pkt_cnt = pkt_cnt_r;

endmodule

// File: tb/tb_task_answer_arbiter.sv
// Directed bench for task_answer_arbiter: vector table plus corner sequences.
module tb_task_answer_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          i_rst;
   logic [N-1:0]  i_valid, o_ready, i_last, o_err;
   logic [N*DW-1:0] i_data;
   logic          o_valid, o_last, i_ready;
   logic [DW-1:0] o_data;
   logic [2:0]    o_id;
   logic [15:0]   o_pkt_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        rdy;
      logic [31:0] base;
      logic        ev;
      logic [31:0] ed;
      logic        el;
      logic [3:0]  er;
      logic [2:0]  eid;
      logic [15:0] ecnt;
   } vec_t;

   vec_t vecs [0:31];
   int   nv = 0;

   task_answer_arbiter #(.N_TASKS(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .o_data(o_data),
      .o_last(o_last), .i_ready(i_ready), .o_id(o_id), .o_err(o_err),
      .o_pkt_cnt(o_pkt_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [31:0] base);
      for (int k = 0; k < N; k++) i_data[k*DW +: DW] = base + 32'(k);
   endtask

   task automatic add(input logic [3:0] v, input logic [3:0] l, input logic r,
                      input logic [31:0] b, input logic ev, input logic [31:0] ed,
                      input logic el, input logic [3:0] er, input logic [2:0] eid,
                      input logic [15:0] ecnt);
      vecs[nv].valid = v;  vecs[nv].last = l;  vecs[nv].rdy = r;  vecs[nv].base = b;
      vecs[nv].ev = ev;    vecs[nv].ed = ed;   vecs[nv].el = el;  vecs[nv].er = er;
      vecs[nv].eid = eid;  vecs[nv].ecnt = ecnt;
      nv++;
   endtask

   task automatic run_vectors(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         i_valid = vecs[i].valid;
         i_last  = vecs[i].last;
         i_ready = vecs[i].rdy;
         set_data(vecs[i].base);
         #1;
         chk($sformatf("vec%0d valid", i), 64'(o_valid), 64'(vecs[i].ev));
         chk($sformatf("vec%0d ready", i), 64'(o_ready), 64'(vecs[i].er));
         chk($sformatf("vec%0d id", i), 64'(o_id), 64'(vecs[i].eid));
         chk($sformatf("vec%0d cnt", i), 64'(o_pkt_cnt), 64'(vecs[i].ecnt));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d data", i), 64'(o_data), 64'(vecs[i].ed));
            chk($sformatf("vec%0d last", i), 64'(o_last), 64'(vecs[i].el));
         end
         tick();
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_valid = '0; i_last = '0; i_ready = 1'b0; i_data = '0;
      tick(); tick();
      i_rst = 1'b0;
   endtask

   initial begin
      int seg0_end, seg1_end, widx, idle;
      logic [3:0] oh;
      logic       rdy;

      // Single 3-word packet from requester 0 after reset.
      add(4'b0001, 4'b0000, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 4'b0000, 3'd0, 16'd0);
      add(4'b0001, 4'b0000, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 4'b0000, 3'd0, 16'd0);
      add(4'b0001, 4'b0000, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 4'b0001, 3'd0, 16'd0);
      add(4'b0001, 4'b0000, 1'b1, 32'h110, 1'b1, 32'h110, 1'b0, 4'b0001, 3'd0, 16'd0);
      add(4'b0001, 4'b0001, 1'b1, 32'h120, 1'b1, 32'h120, 1'b1, 4'b0001, 3'd0, 16'd0);
      add(4'b0000, 4'b0000, 1'b1, 32'h0,   1'b0, 32'h0,   1'b0, 4'b0000, 3'd0, 16'd1);
      seg0_end = nv;
      // All four requesting, 2-word packets: grants 0,1,2,3,0.
      for (int p = 0; p < 5; p++) begin
         logic [31:0] b;
         logic [2:0]  g, pg;
         b  = 32'hA000_0000 + 32'(p) * 32'h100;
         g  = 3'(p % 4);
         pg = (p == 0) ? 3'd0 : 3'((p - 1) % 4);
         oh = 4'b0001 << g;
         add(4'b1111, 4'b0000, 1'b1, b, 1'b0, 32'h0, 1'b0, 4'b0000, pg, 16'(p));
         add(4'b1111, 4'b0000, 1'b1, b, 1'b0, 32'h0, 1'b0, 4'b0000, g,  16'(p));
         add(4'b1111, 4'b0000, 1'b1, b, 1'b1, b + 32'(g), 1'b0, oh, g, 16'(p));
         add(4'b1111, oh, 1'b1, b + 32'h10, 1'b1, b + 32'h10 + 32'(g), 1'b1, oh, g, 16'(p));
      end
      add(4'b0000, 4'b0000, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 4'b0000, 3'd0, 16'd5);
      seg1_end = nv;

      do_reset();
      #1;
      chk("reset valid", 64'(o_valid), 64'd0);
      chk("reset ready", 64'(o_ready), 64'd0);
      chk("reset id", 64'(o_id), 64'd0);
      chk("reset cnt", 64'(o_pkt_cnt), 64'd0);
      chk("reset err", 64'(o_err), 64'd0);
      chk("reset data", 64'(o_data), 64'd0);
      #0;
      run_vectors(0, seg0_end);
      do_reset();
      run_vectors(seg0_end, seg1_end);

      // Requester 1 under toggling downstream ready.
      i_valid = 4'b0010; i_last = '0; i_ready = 1'b1; set_data(32'h5550);
      i_data[DW +: DW] = 32'hB0;
      #1; chk("bp idle valid", 64'(o_valid), 64'd0); tick();
      #1; chk("bp grant id", 64'(o_id), 64'd1);
      chk("bp grant ready", 64'(o_ready), 64'd0); tick();
      widx = 0;
      for (int c = 0; c < 20 && widx < 4; c++) begin
         rdy = (c % 2 == 0);
         i_ready = rdy;
         i_data[DW +: DW] = 32'hB0 + 32'(widx);
         i_last = (widx == 3) ? 4'b0010 : 4'b0000;
         #1;
         chk("bp valid", 64'(o_valid), 64'd1);
         chk("bp data", 64'(o_data), 64'(32'hB0 + 32'(widx)));
         chk("bp last", 64'(o_last), 64'(widx == 3));
         chk("bp ready", 64'(o_ready), 64'(rdy ? 4'b0010 : 4'b0000));
         if (rdy) widx++;
         tick();
      end
      chk("bp all words", 64'(widx), 64'd4);
      i_valid = '0; i_last = '0;
      #1; chk("bp cnt", 64'(o_pkt_cnt), 64'd6);
      chk("bp done valid", 64'(o_valid), 64'd0); tick();

      // Requester 2 stalls after one word: abort marker, held under backpressure.
      i_valid = 4'b0100; i_ready = 1'b1; i_data[2*DW +: DW] = 32'hC2;
      #1; tick();
      #1; chk("to grant id", 64'(o_id), 64'd2); tick();
      #1; chk("to word valid", 64'(o_valid), 64'd1);
      chk("to word ready", 64'(o_ready), 64'(4'b0100)); tick();
      i_valid = '0; i_ready = 1'b0;
      idle = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (o_valid) break;
         idle++;
         tick();
      end
      chk("to idle cycles", 64'(idle), 64'd15);
      chk("abort data", 64'(o_data), 64'(32'hDEAD0002));
      chk("abort last", 64'(o_last), 64'd1);
      chk("abort ready", 64'(o_ready), 64'd0);
      tick();
      for (int h = 0; h < 4; h++) begin
         #1;
         chk("abort hold valid", 64'(o_valid), 64'd1);
         chk("abort hold data", 64'(o_data), 64'(32'hDEAD0002));
         chk("abort hold last", 64'(o_last), 64'd1);
         chk("abort hold cnt", 64'(o_pkt_cnt), 64'd6);
         chk("abort hold err", 64'(o_err), 64'd0);
         tick();
      end
      i_ready = 1'b1;
      #1; chk("abort accept valid", 64'(o_valid), 64'd1); tick();
      i_ready = 1'b0;
      #1;
      chk("abort cnt", 64'(o_pkt_cnt), 64'd7);
      chk("abort err", 64'(o_err), 64'(4'b0100));
      chk("abort idle valid", 64'(o_valid), 64'd0);
      tick();

      // Reset in the middle of a requester 3 packet.
      i_valid = 4'b1000; i_ready = 1'b1; i_last = '0; set_data(32'hD00);
      #1; tick();
      #1; chk("rst grant id", 64'(o_id), 64'd3); tick();
      #1; chk("rst word0 valid", 64'(o_valid), 64'd1); tick();
      #1; chk("rst word1 valid", 64'(o_valid), 64'd1);
      i_rst = 1'b1;
      tick();
      #1;
      chk("mid rst valid", 64'(o_valid), 64'd0);
      chk("mid rst ready", 64'(o_ready), 64'd0);
      chk("mid rst id", 64'(o_id), 64'd0);
      chk("mid rst cnt", 64'(o_pkt_cnt), 64'd0);
      chk("mid rst err", 64'(o_err), 64'd0);
      chk("mid rst last", 64'(o_last), 64'd0);
      chk("mid rst data", 64'(o_data), 64'd0);
      tick();
      i_rst = 1'b0; i_valid = 4'b1111;
      #1; chk("post rst idle", 64'(o_valid), 64'd0); tick();
      #1; chk("post rst id", 64'(o_id), 64'd0); tick();
      #1; chk("post rst ready", 64'(o_ready), 64'(4'b0001));
      chk("post rst data", 64'(o_data), 64'(32'hD00));
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
